// File: rtl/mem_dump_pkg.sv
// Shared types for the data-memory dump sequencer.
// State encoding, word size and index-width helper.
package mem_dump_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_HALT,
        READ,
        SEND,
        DONE
    } state_e;

    // A single-word dump still needs a 1-bit index register.
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_dump_ctrl_mux.sv
// Data-memory port select between the core load/store path and the dump engine.
// The dump side never writes memory.
module mem_port_mux
    import mem_dump_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              sel_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [DATA_W-1:0] core_wdata_i,
    input  logic              core_we_i,
    input  logic [ADDR_W-1:0] dump_addr_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o
);

    always_comb begin
        mem_addr_o  = core_addr_i;
        mem_wdata_o = core_wdata_i;
        mem_we_o    = core_we_i;
        if (sel_i) begin
            mem_addr_o  = dump_addr_i;
            mem_wdata_o = '0;
            mem_we_o    = 1'b0;
        end
    end

endmodule

// File: rtl/mem_dump_ctrl.sv
// Post-halt debug sequencer: takes over the data-memory port and
// streams every word out over a valid/ready channel.
module mem_dump_ctrl
    import mem_dump_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              halt_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [DATA_W-1:0] core_wdata_i,
    input  logic              core_we_i,
    output logic [DATA_W-1:0] core_rdata_o,
    output logic              core_stall_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              dump_valid_o,
    output logic [ADDR_W-1:0] dump_addr_o,
    output logic [DATA_W-1:0] dump_data_o,
    input  logic              dump_ready_i,
    output logic              busy_o,
    output logic              done_o
);

    localparam int IDX_W = idx_w(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              dump_owns;
    logic [ADDR_W-1:0] idx_addr;

    assign dump_owns = (state_q == READ) || (state_q == SEND) || (state_q == DONE);
    assign idx_addr  = ADDR_W'(idx_q) << $clog2(WORD_BYTES);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) state_d = halt_i ? READ : WAIT_HALT;
            end
            WAIT_HALT: begin
                if (halt_i) state_d = READ;
            end
            READ: begin
                data_d  = mem_rdata_i;
                addr_d  = idx_addr;
                valid_d = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (valid_q && dump_ready_i) begin
                    valid_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                idx_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Abort beats a same-cycle handshake and suppresses the done pulse.
        if (abort_i && state_q != IDLE) begin
            state_d = IDLE;
            valid_d = 1'b0;
            idx_d   = '0;
            done_d  = 1'b0;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    mem_port_mux #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_mux (
        .sel_i       (dump_owns),
        .core_addr_i (core_addr_i),
        .core_wdata_i(core_wdata_i),
        .core_we_i   (core_we_i),
        .dump_addr_i (idx_addr),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_we_o    (mem_we_o)
    );

    assign core_rdata_o = mem_rdata_i;
    assign core_stall_o = dump_owns;
    assign dump_valid_o = valid_q;
    assign dump_addr_o  = addr_q;
    assign dump_data_o  = data_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule
